// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution.
// Captures the EX stage each non-stalled cycle, issues a one-cycle fetch
// redirect plus flush on a taken control transfer, then squashes the
// wrong-path EX instructions for SHADOW_CYCLES non-stalled cycles.
module ex_mem_branch_stage #(
    parameter int SHADOW_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_alu_result,
    input  logic             ex_alu_bcond,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [31:0]      ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_mem_to_reg,
    input  logic             mem_stall,
    output logic             mem_valid,
    output logic [31:0]      mem_result,
    output logic [31:0]      mem_store_data,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_to_reg,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             shadow_active,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    localparam logic [2:0] SHD_INIT = 3'(SHADOW_CYCLES);

    state_t      state, state_nxt;
    logic [2:0]  shd_cnt, shd_cnt_nxt;
    logic        eff_valid;
    logic        is_jump;
    logic        take;
    logic        take_cap;
    logic [31:0] target;
    logic [31:0] link;

    assign eff_valid = ex_valid & (state == RUN);
    assign is_jump   = ex_is_jal | ex_is_jalr;
    assign take      = eff_valid & (is_jump | (ex_is_branch & ex_alu_bcond));
    // A held instruction is re-evaluated once the stall releases.
    assign take_cap  = take & ~mem_stall;
    assign target    = ex_is_jalr ? {ex_alu_result[31:1], 1'b0} : ex_pc + ex_imm;
    assign link      = ex_pc + 32'd4;

    // Shadow FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            shd_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            shd_cnt <= shd_cnt_nxt;
        end
    end

    // Next state: enter SHADOW on a taken capture, leave after the window drains.
    always_comb begin
        state_nxt   = state;
        shd_cnt_nxt = shd_cnt;
        if (!mem_stall) begin
            case (state)
                RUN: begin
                    if (take) begin
                        state_nxt   = SHADOW;
                        shd_cnt_nxt = SHD_INIT;
                    end
                end
                SHADOW: begin
                    if (shd_cnt <= 3'd1) begin
                        state_nxt   = RUN;
                        shd_cnt_nxt = 3'd0;
                    end else begin
                        shd_cnt_nxt = shd_cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt   = RUN;
                    shd_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // EX/MEM pipeline register; squashed instructions lose their side effects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid      <= 1'b0;
            mem_result     <= 32'd0;
            mem_store_data <= 32'd0;
            mem_rd         <= 5'd0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
        end else if (!mem_stall) begin
            mem_valid      <= eff_valid;
            mem_result     <= is_jump ? link : ex_alu_result;
            mem_store_data <= ex_rs2_data;
            mem_rd         <= ex_rd;
            mem_reg_write  <= eff_valid & ex_reg_write & ~ex_is_branch;
            mem_mem_read   <= eff_valid & ex_mem_read;
            mem_mem_write  <= eff_valid & ex_mem_write;
            mem_mem_to_reg <= ex_mem_to_reg;
        end
    end

    // One-cycle redirect pulse; target is kept until the next taken transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= take_cap;
            if (take_cap)
                redirect_pc <= target;
        end
    end

    // Saturating count of taken control transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            taken_count <= '0;
        else if (take_cap && (taken_count != {CNT_W{1'b1}}))
            taken_count <= taken_count + CNT_W'(1);
    end

    assign flush         = redirect_valid;
    assign shadow_active = (state == SHADOW);

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage: two instances (1-cycle and 3-cycle shadow,
// the latter with a narrow counter) share stimulus; a squash-window model
// predicts every output cycle by cycle.
module tb_ex_mem_branch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid, ex_alu_bcond, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, ex_alu_result, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, mem_stall;

    logic        a_mem_valid, a_mem_reg_write, a_mem_mem_read, a_mem_mem_write, a_mem_mem_to_reg;
    logic [31:0] a_mem_result, a_mem_store_data, a_redirect_pc;
    logic [4:0]  a_mem_rd;
    logic        a_redirect_valid, a_flush, a_shadow_active;
    logic [15:0] a_taken_count;

    logic        b_mem_valid, b_mem_reg_write, b_mem_mem_read, b_mem_mem_write, b_mem_mem_to_reg;
    logic [31:0] b_mem_result, b_mem_store_data, b_redirect_pc;
    logic [4:0]  b_mem_rd;
    logic        b_redirect_valid, b_flush, b_shadow_active;
    logic [3:0]  b_taken_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_branch_stage #(.SHADOW_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_alu_result(ex_alu_result), .ex_alu_bcond(ex_alu_bcond), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_stall(mem_stall),
        .mem_valid(a_mem_valid), .mem_result(a_mem_result), .mem_store_data(a_mem_store_data),
        .mem_rd(a_mem_rd), .mem_reg_write(a_mem_reg_write), .mem_mem_read(a_mem_mem_read),
        .mem_mem_write(a_mem_mem_write), .mem_mem_to_reg(a_mem_mem_to_reg),
        .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc), .flush(a_flush),
        .shadow_active(a_shadow_active), .taken_count(a_taken_count)
    );

    ex_mem_branch_stage #(.SHADOW_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_alu_result(ex_alu_result), .ex_alu_bcond(ex_alu_bcond), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_stall(mem_stall),
        .mem_valid(b_mem_valid), .mem_result(b_mem_result), .mem_store_data(b_mem_store_data),
        .mem_rd(b_mem_rd), .mem_reg_write(b_mem_reg_write), .mem_mem_read(b_mem_mem_read),
        .mem_mem_write(b_mem_mem_write), .mem_mem_to_reg(b_mem_mem_to_reg),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc), .flush(b_flush),
        .shadow_active(b_shadow_active), .taken_count(b_taken_count)
    );

    // Flattened observed outputs for whole-state comparison against the model.
    logic [124:0] dv_a, dv_b;
    assign dv_a = {a_mem_valid, a_mem_result, a_mem_store_data, a_mem_rd, a_mem_reg_write,
                   a_mem_mem_read, a_mem_mem_write, a_mem_mem_to_reg, a_redirect_valid,
                   a_redirect_pc, a_flush, a_shadow_active, a_taken_count};
    assign dv_b = {b_mem_valid, b_mem_result, b_mem_store_data, b_mem_rd, b_mem_reg_write,
                   b_mem_mem_read, b_mem_mem_write, b_mem_mem_to_reg, b_redirect_valid,
                   b_redirect_pc, b_flush, b_shadow_active, 12'd0, b_taken_count};

    // Reference model: squash_left counts wrong-path captures still to discard.
    typedef struct {
        bit          valid;
        bit [31:0]   result;
        bit [31:0]   sdata;
        bit [4:0]    rd;
        bit          rw, mr, mw, m2r, rv;
        bit [31:0]   rpc;
        int          squash_left;
        int unsigned cnt;
    } mdl_t;

    mdl_t m_a, m_b, zero_m;

    function automatic mdl_t step(mdl_t m, int shadow, int unsigned cmax);
        mdl_t n = m;
        bit   ev, tk;
        n.rv = 1'b0;
        if (!mem_stall) begin
            ev = ex_valid && (m.squash_left == 0);
            tk = ev && (ex_is_jal || ex_is_jalr || (ex_is_branch && ex_alu_bcond));
            n.valid  = ev;
            n.result = (ex_is_jal || ex_is_jalr) ? ex_pc + 32'd4 : ex_alu_result;
            n.sdata  = ex_rs2_data;
            n.rd     = ex_rd;
            n.rw     = ev && ex_reg_write && !ex_is_branch;
            n.mr     = ev && ex_mem_read;
            n.mw     = ev && ex_mem_write;
            n.m2r    = ex_mem_to_reg;
            if (m.squash_left > 0) begin
                n.squash_left = m.squash_left - 1;
            end else if (tk) begin
                n.squash_left = shadow;
                n.rv  = 1'b1;
                n.rpc = ex_is_jalr ? (ex_alu_result & 32'hFFFF_FFFE) : ex_pc + ex_imm;
                if (m.cnt < cmax) n.cnt = m.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [124:0] expv(mdl_t m);
        return {m.valid, m.result, m.sdata, m.rd, m.rw, m.mr, m.mw, m.m2r, m.rv,
                m.rpc, m.rv, (m.squash_left != 0), 16'(m.cnt)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a <= zero_m;
            m_b <= zero_m;
        end else begin
            m_a <= step(m_a, 1, 32'hFFFF);
            m_b <= step(m_b, 3, 15);
        end
    end

    task automatic clr_in();
        ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_alu_result = 0; ex_alu_bcond = 0;
        ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_rs2_data = 0; ex_rd = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; mem_stall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        clr_in();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        clr_in();
        ex_valid = 1; ex_is_jal = 1; ex_alu_result = 32'hDEAD; ex_rd = 7; ex_reg_write = 1;
        repeat (2) tick();
        checks++;
        if (dv_a !== '0) $display("FAIL reset_a: got %h want 0", dv_a);
        if (dv_a !== '0) errors++;
        checks++;
        if (dv_b !== '0) begin errors++; $display("FAIL reset_b: got %h want 0", dv_b); end
        clr_in();
        reset = 1;
        tick();
    endtask

    task automatic test_alu_capture();
        idle(4);
        ex_valid = 1; ex_alu_result = 32'h10; ex_rd = 5; ex_reg_write = 1;
        tick();
        checks++;
        if (a_mem_valid !== 1 || a_mem_result !== 32'h10 || a_mem_rd !== 5 ||
            a_mem_reg_write !== 1 || a_redirect_valid !== 0) begin
            errors++;
            $display("FAIL alu_capture: got v=%b res=%h rd=%0d rw=%b rv=%b want 1 10 5 1 0",
                     a_mem_valid, a_mem_result, a_mem_rd, a_mem_reg_write, a_redirect_valid);
        end
        checks++;
        if (dv_b !== expv(m_b)) begin errors++; $display("FAIL alu_model_b: got %h want %h", dv_b, expv(m_b)); end
    endtask

    task automatic test_branch();
        idle(4);
        ex_valid = 1; ex_is_branch = 1; ex_alu_bcond = 1; ex_pc = 32'h100; ex_imm = 32'h20;
        ex_reg_write = 1;
        tick();
        checks++;
        if (a_redirect_valid !== 1 || a_flush !== 1 || a_redirect_pc !== 32'h120 ||
            a_mem_reg_write !== 0 || a_taken_count !== 16'd1 || a_shadow_active !== 1) begin
            errors++;
            $display("FAIL beq_taken: got rv=%b fl=%b pc=%h rw=%b cnt=%0d sh=%b want 1 1 120 0 1 1",
                     a_redirect_valid, a_flush, a_redirect_pc, a_mem_reg_write, a_taken_count,
                     a_shadow_active);
        end
        clr_in();
        ex_valid = 1; ex_alu_result = 32'h77; ex_rd = 9; ex_reg_write = 1;
        tick();
        checks++;
        if (a_mem_valid !== 0 || a_redirect_valid !== 0 || a_flush !== 0 || a_mem_reg_write !== 0) begin
            errors++;
            $display("FAIL beq_shadow: got v=%b rv=%b fl=%b rw=%b want 0 0 0 0",
                     a_mem_valid, a_redirect_valid, a_flush, a_mem_reg_write);
        end
        tick();
        checks++;
        if (a_mem_valid !== 1 || a_shadow_active !== 0 || a_redirect_pc !== 32'h120) begin
            errors++;
            $display("FAIL beq_after: got v=%b sh=%b pc=%h want 1 0 120",
                     a_mem_valid, a_shadow_active, a_redirect_pc);
        end
    endtask

    task automatic test_jalr();
        idle(4);
        ex_valid = 1; ex_is_jalr = 1; ex_alu_result = 32'h2003; ex_pc = 32'h40; ex_rd = 1;
        ex_reg_write = 1;
        tick();
        checks++;
        if (a_redirect_valid !== 1 || a_redirect_pc !== 32'h2002 || a_mem_result !== 32'h44 ||
            a_mem_reg_write !== 1) begin
            errors++;
            $display("FAIL jalr: got rv=%b pc=%h res=%h rw=%b want 1 2002 44 1",
                     a_redirect_valid, a_redirect_pc, a_mem_result, a_mem_reg_write);
        end
    endtask

    task automatic test_wrap();
        idle(4);
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h8;
        tick();
        checks++;
        if (a_mem_result !== 32'h0 || a_redirect_pc !== 32'h4 || a_redirect_valid !== 1) begin
            errors++;
            $display("FAIL jal_wrap: got res=%h pc=%h rv=%b want 0 4 1",
                     a_mem_result, a_redirect_pc, a_redirect_valid);
        end
    endtask

    task automatic test_stall();
        idle(4);
        ex_valid = 1; ex_alu_result = 32'h55; ex_rd = 3; ex_reg_write = 1;
        tick();
        clr_in();
        ex_valid = 1; ex_is_branch = 1; ex_alu_bcond = 1; ex_pc = 32'h200; ex_imm = 32'h10;
        ex_alu_result = 32'h99;
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_mem_valid !== 1 || a_mem_result !== 32'h55 || a_mem_rd !== 3 ||
                a_redirect_valid !== 0 || a_shadow_active !== 0 || b_redirect_valid !== 0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b res=%h rd=%0d rv=%b sh=%b want 1 55 3 0 0",
                         i, a_mem_valid, a_mem_result, a_mem_rd, a_redirect_valid, a_shadow_active);
            end
        end
        mem_stall = 0;
        tick();
        checks++;
        if (a_redirect_valid !== 1 || a_redirect_pc !== 32'h210 || a_mem_result !== 32'h99) begin
            errors++;
            $display("FAIL stall_release: got rv=%b pc=%h res=%h want 1 210 99",
                     a_redirect_valid, a_redirect_pc, a_mem_result);
        end
    endtask

    task automatic test_shadow3();
        int  squashed;
        bit  seen_valid;
        int  cyc;
        bit  stall_pat [8] = '{0, 1, 0, 1, 1, 0, 0, 0};
        idle(4);
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h300; ex_imm = 32'h40;
        tick();
        clr_in();
        ex_valid = 1; ex_alu_result = 32'hAB; ex_rd = 4; ex_reg_write = 1;
        squashed = 0;
        seen_valid = 0;
        cyc = 0;
        while (!seen_valid && cyc < 20) begin
            mem_stall = (cyc < 8) ? stall_pat[cyc] : 1'b0;
            tick();
            if (cyc == 0) begin
                checks++;
                if (b_redirect_valid !== 0 || b_redirect_pc !== 32'h340) begin
                    errors++;
                    $display("FAIL shadow3_pulse: got rv=%b pc=%h want 0 340", b_redirect_valid, b_redirect_pc);
                end
            end
            if (!mem_stall) begin
                if (b_mem_valid === 1'b1) seen_valid = 1;
                else squashed++;
            end
            cyc++;
        end
        checks++;
        if (squashed !== 3 || !seen_valid) begin
            errors++;
            $display("FAIL shadow3_window: got squashed=%0d valid_seen=%0d want 3 1", squashed, seen_valid);
        end
        checks++;
        if (dv_b !== expv(m_b)) begin errors++; $display("FAIL shadow3_model: got %h want %h", dv_b, expv(m_b)); end
    endtask

    task automatic test_reset_shadow();
        idle(4);
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h500; ex_imm = 32'h4;
        tick();
        checks++;
        if (a_shadow_active !== 1 || b_shadow_active !== 1) begin
            errors++;
            $display("FAIL rst_shadow_pre: got sh_a=%b sh_b=%b want 1 1", a_shadow_active, b_shadow_active);
        end
        #1 reset = 0;
        #1;
        checks++;
        if (dv_a !== '0 || dv_b !== '0) begin
            errors++;
            $display("FAIL rst_shadow_async: got a=%h b=%h want 0", dv_a, dv_b);
        end
        #1 reset = 1;
        clr_in();
        ex_valid = 1; ex_alu_result = 32'h31; ex_rd = 2; ex_reg_write = 1;
        tick();
        checks++;
        if (a_mem_valid !== 1 || b_mem_valid !== 1 || a_mem_result !== 32'h31) begin
            errors++;
            $display("FAIL rst_shadow_after: got va=%b vb=%b res=%h want 1 1 31",
                     a_mem_valid, b_mem_valid, a_mem_result);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            idle(3);
            ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h1000 + 32'(i * 4);
            tick();
        end
        idle(3);
        checks++;
        if (b_taken_count !== 4'hF) begin
            errors++;
            $display("FAIL count_saturate: got %0d want 15", b_taken_count);
        end
        checks++;
        if (a_taken_count !== 16'd20) begin
            errors++;
            $display("FAIL count_a: got %0d want 20", a_taken_count);
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 400; i++) begin
            clr_in();
            ex_valid      = ($urandom_range(0, 9) != 0);
            k             = $urandom_range(0, 5);
            ex_is_branch  = (k == 0);
            ex_is_jal     = (k == 1);
            ex_is_jalr    = (k == 2);
            ex_alu_bcond  = $urandom_range(0, 1);
            ex_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            ex_imm        = $urandom();
            ex_alu_result = $urandom();
            ex_rs2_data   = $urandom();
            ex_rd         = 5'($urandom());
            ex_reg_write  = $urandom_range(0, 1);
            ex_mem_read   = $urandom_range(0, 1);
            ex_mem_write  = $urandom_range(0, 1);
            ex_mem_to_reg = $urandom_range(0, 1);
            mem_stall     = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (dv_a !== expv(m_a)) begin
                errors++;
                $display("FAIL random_a[%0d]: got %h want %h", i, dv_a, expv(m_a));
            end
            checks++;
            if (dv_b !== expv(m_b)) begin
                errors++;
                $display("FAIL random_b[%0d]: got %h want %h", i, dv_b, expv(m_b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_capture();
        test_branch();
        test_jalr();
        test_wrap();
        test_stall();
        test_shadow3();
        test_reset_shadow();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_branch_stage.md
Name: ex_mem_branch_stage

Overview:
- EX/MEM pipeline register placed directly downstream of the ALU in the 5-stage pipelined core.
- Captures the ALU result, the branch condition and the EX control bits each cycle.
- Resolves branches and jumps: builds the target, issues a one-cycle fetch redirect plus a flush of younger stages, then squashes wrong-path EX instructions for a configurable shadow window.
- Holds its contents on memory stall and keeps a saturating count of taken control transfers.

Parameters:
- SHADOW_CYCLES, 1: non-stalled cycles after a redirect during which incoming EX instructions are squashed. Legal range 1..7.
- CNT_W, 16: width of the taken-transfer counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate.
- ex_alu_result  in  32  ALU result.
- ex_alu_bcond  in  1  ALU branch condition.
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  control-transfer type; mutually exclusive.
- ex_rs2_data  in  32  store data, already forwarded.
- ex_rd  in  5  destination register.
- ex_reg_write / ex_mem_read / ex_mem_write / ex_mem_to_reg  in  1 each  EX control bits.
- mem_stall  in  1  MEM stage cannot accept; hold all EX/MEM state.
- mem_valid  out  1  EX/MEM holds a real instruction.
- mem_result  out  32  ALU result, or link address for jumps.
- mem_store_data  out  32
- mem_rd  out  5
- mem_reg_write / mem_mem_read / mem_mem_write / mem_mem_to_reg  out  1 each
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  redirect target.
- flush  out  1  clear IF/ID and ID/EX; equal to redirect_valid.
- shadow_active  out  1  FSM is in SHADOW.
- taken_count  out  CNT_W  saturating count of taken transfers.

Behaviour:
- Reset (reset=0, asynchronous):
  - every output and all internal state go to 0;
  - FSM enters RUN; shadow counter = 0.
- Effective valid: eff_valid = ex_valid & (state==RUN).
- Taken condition: take = eff_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_alu_bcond)).
- Target: jalr gives {ex_alu_result[31:1],1'b0}; branch/jal give ex_pc+ex_imm. Modulo 2^32, wrap allowed.
- Capture (edge with mem_stall=0):
  - mem_valid <= eff_valid;
  - mem_result <= ex_pc+4 for jal/jalr, else ex_alu_result (ex_pc=32'hFFFFFFFC gives link 0);
  - mem_store_data, mem_rd, mem_mem_to_reg copied;
  - mem_reg_write <= eff_valid & ex_reg_write & ~ex_is_branch;
  - mem_mem_read <= eff_valid & ex_mem_read;
  - mem_mem_write <= eff_valid & ex_mem_write.
- mem_stall=1: all mem_* outputs, FSM state and shadow counter hold. take is ignored (no redirect); it is re-evaluated when the stall releases.
- FSM:
  - RUN -> SHADOW on a capture edge with take=1. redirect_pc <= target; redirect_valid <= 1; shadow counter <= SHADOW_CYCLES; taken_count += 1, saturating at all-ones.
  - SHADOW: redirect_valid lasts exactly one cycle (first SHADOW cycle), independent of mem_stall. Each non-stalled edge decrements the counter; when the counter reaches 1 on a non-stalled edge, return to RUN.
  - SHADOW is entered only from RUN; a control transfer inside SHADOW is squashed and ignored.
- redirect_pc holds its last value when redirect_valid=0.
- Latency: EX input to mem_* is 1 cycle; taken EX instruction to redirect_valid is 1 cycle after the capture edge.
- Reset mid-SHADOW: immediate return to RUN, redirect_valid=0, wrong-path squash abandoned.

Test Plan:
- Reset release, ex_valid=1, add: ex_alu_result=32'h10, ex_rd=5, ex_reg_write=1 -> next cycle mem_valid=1, mem_result=32'h10, mem_rd=5, mem_reg_write=1; redirect_valid=0.
- beq taken: ex_pc=32'h100, ex_imm=32'h20, ex_alu_bcond=1 -> next cycle redirect_valid=1 and flush=1 for one cycle, redirect_pc=32'h120, mem_reg_write=0, taken_count=1. An instruction presented in the following cycle (SHADOW_CYCLES=1) gives mem_valid=0.
- jalr: ex_alu_result=32'h2003, ex_pc=32'h40 -> redirect_pc=32'h2002, mem_result=32'h44.
- mem_stall=1 held 3 cycles with a taken branch in EX -> mem_* unchanged, no redirect. Stall drops -> redirect on the next cycle.
- SHADOW_CYCLES=3 with mem_stall pulsing mid-shadow -> exactly 3 non-stalled squashed captures, then the next instruction gives mem_valid=1.
- Reset asserted while shadow_active=1 -> all outputs 0 asynchronously; the first instruction after release is captured valid.
